imem_load_controller: RTL and testbench



---
 rtl/imem_load_controller.sv | 188 ++++++++++++++++++
 tb/tb_imem_load_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_controller.sv
// UART program loader for the instruction memory.
// Parses a framed image (sync, word count, big-endian words, checksum), writes each
// word to the instruction memory as soon as its low byte arrives, and keeps the CPU
// held until a frame with a matching checksum has been fully written.
module imem_load_controller #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DEPTH          = 32,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned CntW   = ADDR_W + 1;
    localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StCount, StDataHi, StDataLo, StCheck, StDone, StError
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     n_q, n_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          csum_q, csum_d;
    logic [CntW-1:0]     wl_q, wl_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [TimerW-1:0]   timer_q, timer_d;

    logic                in_frame;
    logic                timeout;
    logic [CntW-1:0]     wl_inc;

    // Timer only runs while a frame is being received.
    assign in_frame = (state_q == StCount) || (state_q == StDataHi) ||
                      (state_q == StDataLo) || (state_q == StCheck);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout  = in_frame && !rx_valid && (timer_q == TimerMax);
    assign wl_inc   = wl_q + CntW'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        wl_d    = wl_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        timer_d = '0;

        if (!rx_valid && in_frame && (timer_q != TimerMax)) begin
            timer_d = timer_q + TimerW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (rx_valid) begin
                    if ((rx_data == 8'd0) || (32'(rx_data) > DEPTH)) begin
                        state_d = StError;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        hold_d  = 1'b1;
                    end else begin
                        n_d     = CntW'(rx_data);
                        csum_d  = 8'd0;
                        wl_d    = '0;
                        addr_d  = '0;
                        state_d = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q + rx_data;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = wl_q[ADDR_W-1:0];
                    wdata_d = {hi_q, rx_data};
                    csum_d  = csum_q + rx_data;
                    wl_d    = wl_inc;
                    state_d = (wl_inc == n_q) ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StError;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        hold_d  = 1'b1;
                    end
                end
            end
            StDone, StError: begin
                // A new sync re-arms the hold before any word of the new image lands.
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = StCount;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            state_d = StError;
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            n_q     <= '0;
            hi_q    <= 8'd0;
            csum_q  <= 8'd0;
            wl_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'd0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            wl_q    <= wl_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: directed frame table, timeout and reset sequences,
// and randomized frames checked against a frame-level model of the expected image.
module tb_imem_load_controller;

    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned TO    = 50;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    imem_load_controller #(
        .ADDR_W         (AW),
        .DEPTH          (DEPTH),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW+15:0] wr_q[$];   // observed writes {addr, data}
    logic [AW+15:0] exp_q[$];  // expected writes
    logic [7:0]     frame_q[$];

    // Every negedge with mem_we high is one observed write.
    always @(negedge CLK) begin
        if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    end

    typedef struct {
        int              nb;
        logic [0:7][7:0] b;
        int              nw;
        logic [0:1][20:0] wr;
        logic            done;
        logic            err;
        logic            hold;
        int              wl;    // -1: not checked
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge. gap=0 gives back-to-back strobes.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic send_frame(input int gapmax);
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : int'($urandom_range(0, gapmax)));
        end
    endtask

    task automatic check_frame(input string tag, input logic done, input logic err,
                               input logic hold, input int wl);
        check({tag, ".nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check($sformatf("%s.write%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        end
        check({tag, ".load_done"}, 32'(load_done), 32'(done));
        check({tag, ".load_error"}, 32'(load_error), 32'(err));
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
        if (wl >= 0) check({tag, ".words_loaded"}, 32'(words_loaded), wl);
        wr_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".mem_we"}, 32'(mem_we), 0);
        check({tag, ".mem_addr"}, 32'(mem_addr), 0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, ".cpu_hold"}, 32'(cpu_hold), 1);
        check({tag, ".load_done"}, 32'(load_done), 0);
        check({tag, ".load_error"}, 32'(load_error), 0);
        check({tag, ".words_loaded"}, 32'(words_loaded), 0);
    endtask

    // Builds a well-formed frame of n random words; queues expected writes.
    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0]  sum;
        logic [15:0] w;
        sum = 8'd0;
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
            exp_q.push_back({5'(i), w});
        end
        frame_q.push_back(corrupt ? sum + 8'($urandom_range(1, 255)) : sum);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{7, {8'hA5, 8'h02, 8'h40, 8'h08, 8'h41, 8'h02, 8'h8B, 8'h00}, 2,
                    {{5'd0, 16'h4008}, {5'd1, 16'h4102}}, 1'b1, 1'b0, 1'b0, 2};
        vecs[1] = '{7, {8'hA5, 8'h02, 8'h40, 8'h08, 8'h41, 8'h02, 8'h8C, 8'h00}, 2,
                    {{5'd0, 16'h4008}, {5'd1, 16'h4102}}, 1'b0, 1'b1, 1'b1, 2};
        vecs[2] = '{7, {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h46, 8'h00}, 1,
                    {{5'd0, 16'h1234}, 21'd0}, 1'b1, 1'b0, 1'b0, 1};
        vecs[3] = '{2, {8'hA5, 8'h21, 48'd0}, 0, 42'd0, 1'b0, 1'b1, 1'b1, -1};
        vecs[4] = '{2, {8'hA5, 8'h00, 48'd0}, 0, 42'd0, 1'b0, 1'b1, 1'b1, -1};

        // Reset state.
        repeat (3) @(negedge CLK);
        check_reset("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        // Directed frame table.
        for (int v = 0; v < 5; v++) begin
            frame_q.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].nb; i++) frame_q.push_back(vecs[v].b[i]);
            for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(vecs[v].wr[i]);
            send_frame(2);
            check_frame($sformatf("vec%0d", v), vecs[v].done, vecs[v].err, vecs[v].hold,
                        vecs[v].wl);
        end

        // Timeout: silence after one word expires exactly TO cycles after the last strobe.
        frame_q = '{8'hA5, 8'h03, 8'h11, 8'h22};
        exp_q   = '{{5'd0, 16'h1122}};
        send_frame(0);
        repeat (TO - 1) @(negedge CLK);
        check("timeout.before_expiry", 32'(load_error), 0);
        @(negedge CLK);
        check_frame("timeout", 1'b0, 1'b1, 1'b1, 1);

        // Keep-alive: a byte on the expiry cycle is accepted.
        exp_q = '{{5'd0, 16'h1122}, {5'd1, 16'h3344}, {5'd2, 16'h5566}};
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, TO - 1);
        send_byte(8'h33, 0);
        check("keepalive.no_error", 32'(load_error), 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h65, 0);
        check_frame("keepalive", 1'b1, 1'b0, 1'b0, 3);

        // Randomized frames against the frame-level model.
        for (int it = 0; it < 20; it++) begin
            int         n;
            bit         bad_n;
            bit         bad_ck;
            logic [7:0] junk;
            frame_q.delete();
            exp_q.delete();
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                frame_q.push_back(junk);
            end
            bad_n  = ($urandom_range(0, 7) == 0);
            bad_ck = ($urandom_range(0, 3) == 0);
            if (bad_n) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255));
                frame_q.push_back(8'hA5);
                frame_q.push_back(8'(n));
                send_frame(3);
                check_frame($sformatf("rand%0d", it), 1'b0, 1'b1, 1'b1, -1);
            end else begin
                n = $urandom_range(1, DEPTH);
                build_frame(n, bad_ck);
                send_frame(3);
                check_frame($sformatf("rand%0d", it), !bad_ck, bad_ck, bad_ck, n);
            end
        end

        // Make sure we start the reset test from DONE.
        frame_q.delete();
        exp_q.delete();
        build_frame(1, 1'b0);
        send_frame(0);
        check_frame("pre_abort", 1'b1, 1'b0, 1'b0, 1);

        // Abort a 32-word frame during word 10 with reset.
        frame_q.delete();
        exp_q.delete();
        build_frame(DEPTH, 1'b0);
        frame_q = frame_q[0:22];   // sync, count, words 0..9, hi byte of word 10
        send_frame(0);
        check("abort.writes_before_reset", wr_q.size(), 10);
        RST_N = 1'b0;
        @(negedge CLK);
        check_reset("abort");
        RST_N = 1'b1;
        wr_q.delete();
        @(negedge CLK);

        // Fresh full-depth frame after the abort.
        frame_q.delete();
        exp_q.delete();
        build_frame(DEPTH, 1'b0);
        send_frame(1);
        if (wr_q.size() > 0) check("full.last_addr", 32'(wr_q[wr_q.size()-1][20:16]), 31);
        check_frame("full", 1'b1, 1'b0, 1'b0, DEPTH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
